// File: rtl/block_checker.sv
// rtl/block_checker.sv - streaming begin/end keyword-balance checker, one ASCII byte per clock.
// Optional feature: BLOCKCHECKER_OVF_EN turns a begin at full depth into a sticky error (else depth saturates).
module block_checker #(
  parameter int DEPTH_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in,
  output logic       result
);

  typedef enum logic [3:0] {
    S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  state_t               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 err_q, err_d;
  logic [7:0]           ch;

  // Fold upper-case letters onto lower case; other bytes keep bit 5 as-is.
  always_comb begin
    ch = in;
    if (in >= 8'h41 && in <= 8'h5a) ch = in | 8'h20;
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    err_d   = err_q;
    if (in == 8'h20) begin
      state_d = S_IDLE;
      if (!err_q) begin
        if (state_q == S_BEGIN) begin
          if (depth_q != DEPTH_MAX) begin
            depth_d = depth_q + DEPTH_ONE;
          end
`ifdef BLOCKCHECKER_OVF_EN
          else begin
            err_d = 1'b1;
          end
`endif
        end else if (state_q == S_END) begin
          if (depth_q == '0) err_d = 1'b1;
          else               depth_d = depth_q - DEPTH_ONE;
        end
      end
    end else begin
      state_d = S_OTHER;
      case (state_q)
        S_IDLE: begin
          if (ch == 8'h62)      state_d = S_B;
          else if (ch == 8'h65) state_d = S_E;
        end
        S_B:    if (ch == 8'h65) state_d = S_BE;
        S_BE:   if (ch == 8'h67) state_d = S_BEG;
        S_BEG:  if (ch == 8'h69) state_d = S_BEGI;
        S_BEGI: if (ch == 8'h6e) state_d = S_BEGIN;
        S_E:    if (ch == 8'h6e) state_d = S_EN;
        S_EN:   if (ch == 8'h64) state_d = S_END;
        default: state_d = S_OTHER;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // The word in progress is judged as if a space followed it now.
  always_comb begin
    result = 1'b0;
    if (!err_q) begin
      case (state_q)
        S_BEGIN: result = 1'b0;
        S_END:   result = (depth_q == DEPTH_ONE);
        default: result = (depth_q == '0);
      endcase
    end
  end

endmodule

// File: tb/tb_block_checker.sv
// tb/tb_block_checker.sv - self-checking bench for block_checker (DEPTH_W=2, optional BLOCKCHECKER_OVF_EN).
module tb_block_checker;

  localparam int DW   = 2;
  localparam int MAXD = (1 << DW) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_c = 8'h20;
  logic       result;

  block_checker #(.DEPTH_W(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in_c),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference model: the text of the current word, a nesting count and an error flag.
  int               m_depth = 0;
  bit               m_err   = 1'b0;
  byte unsigned     m_word[$];

  int    n_cmp = 0;
  int    n_bad = 0;
  bit    started = 1'b0;
  int    lit_seq = 0;
  int    lit_done = 0;
  bit    lit_exp;
  string lit_name;

  function automatic byte unsigned lc(byte unsigned c);
    if (c >= 8'h41 && c <= 8'h5a) return c + 8'h20;
    return c;
  endfunction

  function automatic bit is_kw(string k);
    if (m_word.size() != k.len()) return 1'b0;
    for (int i = 0; i < k.len(); i++)
      if (lc(m_word[i]) != byte'(k[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_result();
    if (m_err)         return 1'b0;
    if (is_kw("begin")) return 1'b0;
    if (is_kw("end"))   return (m_depth == 1);
    return (m_depth == 0);
  endfunction

  task automatic model_step(byte unsigned c);
    if (c == 8'h20) begin
      if (!m_err) begin
        if (is_kw("begin")) begin
          if (m_depth < MAXD) m_depth++;
`ifdef BLOCKCHECKER_OVF_EN
          else m_err = 1'b1;
`endif
        end else if (is_kw("end")) begin
          if (m_depth == 0) m_err = 1'b1;
          else m_depth--;
        end
      end
      m_word.delete();
    end else begin
      m_word.push_back(c);
    end
  endtask

  task automatic model_reset();
    m_depth = 0;
    m_err   = 1'b0;
    m_word.delete();
  endtask

  always @(negedge clk) begin
    if (started) begin
      n_cmp++;
      if (result !== model_result()) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t: result=%b expected %b", $time, result, model_result());
      end
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      n_cmp++;
      if (result !== lit_exp) begin
        n_bad++;
        $display("FAIL %s: result=%b expected %b", lit_name, result, lit_exp);
      end
    end
  end

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) begin
      in_c = byte'(s[i]);
      @(posedge clk);
      model_step(byte'(s[i]));
      #1;
    end
  endtask

  task automatic expect_lit(string name, bit v);
    lit_name = name;
    lit_exp  = v;
    lit_seq++;
  endtask

  task automatic reset_pulse(string name);
    reset = 1'b0;
    model_reset();
    expect_lit(name, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    started = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_lit("reset_hold", 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    send("   ");
    expect_lit("idle_spaces", 1'b1);

    send("begin");      expect_lit("basic_after_n", 1'b0);
    send(" e");         expect_lit("basic_after_e", 1'b0);
    send("n");          expect_lit("basic_after_en", 1'b0);
    send("d");          expect_lit("basic_after_d", 1'b1);
    send(" ");          expect_lit("basic_final_space", 1'b1);

    send("begin enDbegin xyzz eNd ");  expect_lit("mixed_after_eNd", 1'b1);
    send("BeGin ");                    expect_lit("mixed_after_BeGin", 1'b0);
    send("begin end ");                expect_lit("mixed_second_end", 1'b0);
    send("endbegin end ");             expect_lit("mixed_final_end", 1'b1);
    send("beginx ");                   expect_lit("beginx_not_kw", 1'b1);

    reset_pulse("reset_before_underflow");
    send("end");                       expect_lit("underflow_after_d", 1'b0);
    send(" begin end ");               expect_lit("underflow_sticky", 1'b0);

    reset_pulse("reset_clears_err");
    send("begin beg");                 expect_lit("midword_pending", 1'b0);
    reset_pulse("async_reset_midword");
    send("end ");                      expect_lit("post_reset_underflow", 1'b0);

    reset_pulse("reset_before_overflow");
    repeat (4) send("begin ");
    expect_lit("overflow_four_begins", 1'b0);
`ifdef BLOCKCHECKER_OVF_EN
    repeat (4) send("end ");
    expect_lit("overflow_err_sticky", 1'b0);
`else
    repeat (3) send("end ");
    expect_lit("saturate_three_ends", 1'b1);
`endif
    send("  ");
    @(negedge clk);
    #1;
    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
